// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the default bit timing.
// Transmitter and receiver both take CLKS_PER_BIT from here so they stay matched.
package uart_pkg;

    localparam int UART_CLKS_PER_BIT = 120;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } uart_rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous level input.
// Resets to RESET_VAL so an idle-high line does not look like activity.
module uart_rx_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic I_clk,
    input  logic I_reset,
    input  logic I_async,
    output logic O_sync
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= I_async;
            r_sync <= r_meta;
        end
    end

    assign O_sync = r_sync;

endmodule

// File: rtl/uart_rx.sv
// UART receiver (8N1) with a byte holding register, framing-error and overrun pulses.
// Defining UART_RX_PARITY_EN switches to 8E1 frames and adds the O_parity_err pulse.
// state  | meaning
// IDLE   | line idle, waiting for rx_s low
// START  | start bit seen, re-check at half bit period
// DATA   | sampling 8 data bits, LSB first
// PARITY | sampling the even-parity bit
// STOP   | sampling stop bit: commit byte or flag framing error
// BREAK  | stop bit was low, wait for line to return high
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic       I_clk,
    input  logic       I_reset,
    input  logic       I_rx,
    input  logic       I_read,
    output logic [7:0] O_data,
    output logic       O_valid,
    output logic       O_frame_err,
    output logic       O_overrun,
`ifdef UART_RX_PARITY_EN
    output logic       O_parity_err,
`endif
    output logic       O_busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);

    uart_rx_state_e   r_state;
    uart_rx_state_e   w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shreg;
    logic [7:0]       r_data;
    logic             r_valid;
    logic             r_frame_err;
    logic             r_overrun;
    logic             w_rx_s;
    logic             w_cnt_clr;
    logic             w_shift;
    logic             w_commit;
    logic             w_commit_ok;
    logic             w_frame_err;
`ifdef UART_RX_PARITY_EN
    logic             w_par_sample;
    logic             r_parity_bad;
    logic             r_parity_err;
`endif

    uart_rx_sync #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .I_clk   (I_clk),
        .I_reset (I_reset),
        .I_async (I_rx),
        .O_sync  (w_rx_s)
    );

    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_clr   = 1'b0;
        w_shift     = 1'b0;
        w_commit    = 1'b0;
        w_frame_err = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_sample = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                w_cnt_clr = 1'b1;
                if (!w_rx_s) begin
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (r_cnt == CNT_HALF) begin
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = w_rx_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (r_cnt == CNT_FULL) begin
                    w_cnt_clr = 1'b1;
                    w_shift   = 1'b1;
                    if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        w_state_nxt = ST_PARITY;
`else
                        w_state_nxt = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (r_cnt == CNT_FULL) begin
                    w_cnt_clr    = 1'b1;
                    w_par_sample = 1'b1;
                    w_state_nxt  = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (r_cnt == CNT_FULL) begin
                    w_cnt_clr = 1'b1;
                    if (w_rx_s) begin
                        w_commit    = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_frame_err = 1'b1;
                        w_state_nxt = ST_BREAK;
                    end
                end
            end
            // A held-low line must not be mistaken for a new start bit.
            ST_BREAK: begin
                w_cnt_clr = 1'b1;
                if (w_rx_s) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_cnt_clr   = 1'b1;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

`ifdef UART_RX_PARITY_EN
    assign w_commit_ok = w_commit & ~r_parity_bad;
`else
    assign w_commit_ok = w_commit;
`endif

    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shreg     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_cnt <= w_cnt_clr ? '0 : r_cnt + CNT_W'(1);

            if (r_state == ST_START && w_state_nxt == ST_DATA) begin
                r_bit_idx <= '0;
            end else if (w_shift) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end

            if (w_shift) begin
                r_shreg[r_bit_idx] <= w_rx_s;
            end

            r_frame_err <= w_frame_err;
            r_overrun   <= 1'b0;

            // A commit takes priority over a read landing in the same cycle.
            if (w_commit_ok) begin
                r_data    <= r_shreg;
                r_valid   <= 1'b1;
                r_overrun <= r_valid & ~I_read;
            end else if (I_read) begin
                r_valid <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            r_parity_bad <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            if (w_par_sample) begin
                r_parity_bad <= w_rx_s ^ (^r_shreg);
            end
            r_parity_err <= w_commit & r_parity_bad;
        end
    end

    assign O_parity_err = r_parity_err;
`endif

    assign O_data      = r_data;
    assign O_valid     = r_valid;
    assign O_frame_err = r_frame_err;
    assign O_overrun   = r_overrun;
    assign O_busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: a transmitter-style driver plus a timeline model that predicts
// every output per cycle from frame start times and the receiver's latency rule.
module tb_uart_rx;

    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS   = 10;
    localparam int LAT_LIT = 171;
`else
    localparam int NBITS   = 9;
    localparam int LAT_LIT = 155;
`endif
    localparam int FRAME_LEN  = (NBITS + 1) * CPB;
    localparam int COMMIT_OFS = 3 + CPB / 2 + NBITS * CPB;
    localparam int MAXC       = 32768;
    localparam int EV_NONE    = 0;
    localparam int EV_COMMIT  = 1;
    localparam int EV_FERR    = 2;
    localparam int EV_PERR    = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic       rd  = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic       ferr;
    logic       ovr;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       perr;
`endif

    uart_rx #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .I_clk        (clk),
        .I_reset      (rst),
        .I_rx         (rx),
        .I_read       (rd),
        .O_data       (data),
        .O_valid      (valid),
        .O_frame_err  (ferr),
        .O_overrun    (ovr),
`ifdef UART_RX_PARITY_EN
        .O_parity_err (perr),
`endif
        .O_busy       (busy)
    );

    always #5 clk = ~clk;

    int         cyc = 0;
    logic       rd_q = 1'b0;
    logic       rst_q = 1'b1;
    int         checks = 0;
    int         errors = 0;
    bit         model_en = 1'b0;
    bit         rand_rd_en = 1'b0;
    int         ev_kind [MAXC];
    logic [7:0] ev_byte [MAXC];
    int         busy_exp [MAXC];
    logic       m_valid = 1'b0;
    logic [7:0] m_data = 8'h00;
    logic       valid_d = 1'b0;
    int         last_rise = -1;
    int         ferr_cnt = 0;
    int         ovr_cnt = 0;
    int         perr_cnt = 0;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rd_q  <= rd;
        rst_q <= rst;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin : cmp
        int   k;
        logic e_ferr;
        logic e_ovr;
        logic e_perr;
        if (valid && !valid_d) last_rise = cyc;
        valid_d = valid;
        if (ferr) ferr_cnt++;
        if (ovr) ovr_cnt++;
`ifdef UART_RX_PARITY_EN
        if (perr) perr_cnt++;
`endif
        if (model_en) begin
            k      = (cyc < MAXC) ? ev_kind[cyc] : EV_NONE;
            e_ferr = 1'b0;
            e_ovr  = 1'b0;
            e_perr = 1'b0;
            if (rst_q) begin
                m_valid = 1'b0;
                m_data  = 8'h00;
            end else if (k == EV_COMMIT) begin
                e_ovr   = m_valid && !rd_q;
                m_valid = 1'b1;
                m_data  = ev_byte[cyc];
            end else begin
                if (rd_q) m_valid = 1'b0;
                e_ferr = (k == EV_FERR);
                e_perr = (k == EV_PERR);
            end
            chk("valid", valid, m_valid);
            chk("data", data, m_data);
            chk("frame_err", ferr, e_ferr);
            chk("overrun", ovr, e_ovr);
`ifdef UART_RX_PARITY_EN
            chk("parity_err", perr, e_perr);
`endif
            if (rst_q) chk("busy_in_reset", busy, 0);
            else if (cyc < MAXC && busy_exp[cyc] >= 0) chk("busy", busy, 32'(busy_exp[cyc]));
        end
    end

    task automatic mark_busy(input int from, input int to, input int v);
        for (int i = from; i <= to; i++) begin
            if (i >= 0 && i < MAXC) busy_exp[i] = v;
        end
    endtask

    task automatic hold(input logic v, input int n);
        rx = v;
        for (int i = 0; i < n; i++) begin
            if (rand_rd_en) rd = ($urandom_range(0, 5) == 0);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic read_pulse();
        rd = 1'b1;
        @(posedge clk);
        #1;
        rd = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic par_ok,
                              output int st);
        int kind;
        st   = cyc;
        kind = !stop_v ? EV_FERR : (par_ok ? EV_COMMIT : EV_PERR);
        if (st + COMMIT_OFS < MAXC) begin
            ev_kind[st + COMMIT_OFS] = kind;
            ev_byte[st + COMMIT_OFS] = b;
        end
        mark_busy(st + 3, st + COMMIT_OFS - 1, 1);
        if (stop_v) mark_busy(st + COMMIT_OFS, st + COMMIT_OFS + 7, 0);
        else        mark_busy(st + COMMIT_OFS, st + FRAME_LEN + 1, 1);
        hold(1'b0, CPB);
        for (int i = 0; i < 8; i++) hold(b[i], CPB);
`ifdef UART_RX_PARITY_EN
        hold(par_ok ? ^b : ~^b, CPB);
`endif
        hold(stop_v, CPB);
    endtask

    task automatic send_abort(input logic [7:0] b);
        int st;
        st = cyc;
        mark_busy(st + 3, st + 88, 1);
        mark_busy(st + 90, st + 130, 0);
        hold(1'b0, CPB);
        for (int i = 0; i < 4; i++) hold(b[i], CPB);
        hold(b[4], CPB / 2);
        rst = 1'b1;
        rx  = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: cycle budget exceeded at cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int   st;
        int   g;
        int   c0;
        int   c1;
        logic [7:0] b;
        logic stop_v;
        logic pok;

        for (int i = 0; i < MAXC; i++) begin
            ev_kind[i]  = EV_NONE;
            ev_byte[i]  = 8'h00;
            busy_exp[i] = -1;
        end

        repeat (4) @(posedge clk);
        #1;
        model_en = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_valid", valid, 0);
        chk("reset_data", data, 0);
        chk("reset_busy", busy, 0);
        chk("reset_frame_err", ferr, 0);
        chk("reset_overrun", ovr, 0);
        rst = 1'b0;
        mark_busy(cyc, cyc + 12, 0);
        hold(1'b1, 10);

        // 0xA5: latency, data, no flags, read clears
        c0 = ferr_cnt;
        c1 = ovr_cnt;
        last_rise = -1;
        send_frame(8'hA5, 1'b1, 1'b1, st);
        chk("a5_latency", last_rise - st, LAT_LIT);
        chk("a5_data", data, 8'hA5);
        chk("a5_valid", valid, 1);
        chk("a5_no_flags", (ferr_cnt - c0) + (ovr_cnt - c1), 0);
        read_pulse();
        chk("a5_read_clears", valid, 0);
        hold(1'b1, 5);

        // 0x00 then 0xFF back-to-back without read
        c1 = ovr_cnt;
        send_frame(8'h00, 1'b1, 1'b1, st);
        send_frame(8'hFF, 1'b1, 1'b1, st);
        chk("ovr_pulses", ovr_cnt - c1, 1);
        chk("ovr_data", data, 8'hFF);
        chk("ovr_valid", valid, 1);
        read_pulse();
        hold(1'b1, 5);

        // 5-cycle low glitch on idle line
        g = cyc;
        mark_busy(g + 3, g + 10, 1);
        mark_busy(g + 11, g + 34, 0);
        hold(1'b0, 5);
        hold(1'b1, 30);
        chk("glitch_valid", valid, 0);
        chk("glitch_busy", busy, 0);

        // 0x3C with low stop bit, line held low, then 0x5A
        c0 = ferr_cnt;
        send_frame(8'h3C, 1'b0, 1'b1, st);
        mark_busy(st + FRAME_LEN + 2, st + FRAME_LEN + 42, 1);
        mark_busy(st + FRAME_LEN + 43, st + FRAME_LEN + 52, 0);
        hold(1'b0, 40);
        hold(1'b1, 10);
        chk("ferr_pulses", ferr_cnt - c0, 1);
        chk("ferr_valid", valid, 0);
        send_frame(8'h5A, 1'b1, 1'b1, st);
        chk("after_break_data", data, 8'h5A);
        chk("after_break_valid", valid, 1);

        // reset in the middle of DATA bit 4, then 0x81
        send_abort(8'($urandom));
        chk("midrst_valid", valid, 0);
        chk("midrst_data", data, 0);
        chk("midrst_busy", busy, 0);
        hold(1'b1, 40);
        send_frame(8'h81, 1'b1, 1'b1, st);
        chk("after_rst_data", data, 8'h81);
        chk("after_rst_valid", valid, 1);
        read_pulse();
        hold(1'b1, 5);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1, st);
        chk("par_good_data", data, 8'h07);
        chk("par_good_valid", valid, 1);
        read_pulse();
        hold(1'b1, 5);
        c0 = perr_cnt;
        send_frame(8'h07, 1'b1, 1'b0, st);
        chk("par_bad_pulses", perr_cnt - c0, 1);
        chk("par_bad_valid", valid, 0);
        hold(1'b1, 5);
`endif

        // randomized traffic with random CPU reads
        rand_rd_en = 1'b1;
        for (int n = 0; n < 40; n++) begin
            b      = 8'($urandom);
            stop_v = ($urandom_range(0, 7) != 0);
`ifdef UART_RX_PARITY_EN
            pok    = ($urandom_range(0, 7) != 0);
`else
            pok    = 1'b1;
`endif
            send_frame(b, stop_v, pok, st);
            if (stop_v) hold(1'b1, $urandom_range(0, 8));
            else        hold(1'b1, $urandom_range(4, 12));
        end
        rand_rd_en = 1'b0;
        rd = 1'b0;
        hold(1'b1, 20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
